// File: rtl/wb_burst_arbiter_pkg.sv
// Shared types, CTI codes and helpers for the Wishbone burst arbiter.
package wb_burst_arbiter_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Rotating-priority encoder: first requester after last_i, wrapping.
module wb_rr_picker
  import wb_burst_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    logic [IW-1:0] j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(last_i) + i) % N);
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o = j;
        found = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/wb_burst_arbiter.sv
// Round-robin Wishbone B3 arbiter, grant held for the whole cyc.
// Optional stall watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_burst_arbiter
  import wb_burst_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int IW = clog2(NUM_MASTERS);
  localparam int SW = DW / 8;

  state_e state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic pick_vld;
  logic cyc_sel;
  logic stb_sel;
  logic tmo;

  wb_rr_picker #(
    .N (NUM_MASTERS),
    .IW(IW)
  ) u_picker (
    .req_i  (wbm_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_vld)
  );

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    cyc_sel = 1'b0;
    stb_sel = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (grant_q[m]) begin
        wbs_adr_o = wbm_adr_i[m*AW +: AW];
        wbs_dat_o = wbm_dat_i[m*DW +: DW];
        wbs_sel_o = wbm_sel_i[m*SW +: SW];
        wbs_we_o = wbm_we_i[m];
        wbs_cti_o = wbm_cti_i[m*3 +: 3];
        wbs_bte_o = wbm_bte_i[m*2 +: 2];
        cyc_sel = wbm_cyc_i[m];
        stb_sel = wbm_stb_i[m];
      end
    end
  end

  // A watchdog expiry hides the slave and answers the master with err.
  assign wbs_cyc_o = cyc_sel & ~tmo;
  assign wbs_stb_o = stb_sel & ~tmo;
  assign wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i & ~tmo}};
  assign wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i | tmo}};
  assign wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i & ~tmo}};
  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign grant_o = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          last_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!cyc_sel) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WW = clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic rsp;

  assign rsp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign tmo = (state_q == ST_BUSY) && (wd_q == WW'(TIMEOUT));

  always_comb begin
    wd_d = '0;
    if (state_q == ST_BUSY && stb_sel && !tmo && !rsp)
      wd_d = wd_q + WW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) wd_q <= '0;
    else wd_q <= wd_d;
  end
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Self-checking bench: directed corner cases plus a randomized
// multi-master run checked by a transaction scoreboard.
module tb_wb_burst_arbiter;
  import wb_burst_arbiter_pkg::*;

  localparam int N = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*4-1:0] m_sel;
  logic [N-1:0] m_we, m_cyc, m_stb;
  logic [N*3-1:0] m_cti;
  logic [N*2-1:0] m_bte;
  logic [N*DW-1:0] wbm_dat_o;
  logic [N-1:0] wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [3:0] wbs_sel_o;
  logic wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0] wbs_cti_o;
  logic [1:0] wbs_bte_o;
  logic [DW-1:0] s_dat;
  logic s_ack, s_err, s_rty;

  wb_burst_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbm_adr_i(m_adr),
    .wbm_dat_i(m_dat),
    .wbm_sel_i(m_sel),
    .wbm_we_i (m_we),
    .wbm_cyc_i(m_cyc),
    .wbm_stb_i(m_stb),
    .wbm_cti_i(m_cti),
    .wbm_bte_i(m_bte),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .wbs_rty_i(s_rty),
    .grant_o  (grant_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_beats = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic c,
                     input logic [31:0] a, input logic [2:0] t);
    m_cyc[m] = c;
    m_stb[m] = c;
    m_we[m] = 1'b0;
    m_adr[m*AW +: AW] = a;
    m_dat[m*DW +: DW] = '0;
    m_sel[m*4 +: 4] = 4'hF;
    m_cti[m*3 +: 3] = t;
    m_bte[m*2 +: 2] = 2'b00;
  endtask

  // Scoreboard: beats each master has issued but the slave not yet taken
  beat_t exp_q[N][$];
  logic mon_en = 1'b0;
  logic [N-1:0] exp_gnt;
  int mdl_last;

  always @(negedge clk) begin
    if (mon_en) begin
      int gi;
      int c;
      beat_t e;
      gi = -1;
      for (int m = 0; m < N; m++) if (exp_gnt[m]) gi = m;
      chk("grant", grant_o, exp_gnt);
      chk("slv_cyc", wbs_cyc_o, (gi >= 0) ? m_cyc[gi] : 1'b0);
      chk("ack_route", wbm_ack_o,
          (gi >= 0 && s_ack) ? (64'd1 << gi) : 64'd0);
      if (s_ack && wbs_cyc_o && wbs_stb_o) begin
        n_beats++;
        if (gi < 0) begin
          chk("beat_without_grant", 1'b1, 1'b0);
        end else if (exp_q[gi].size() == 0) begin
          chk("beat_unexpected", gi, 64'hFFFF);
        end else begin
          e = exp_q[gi].pop_front();
          chk("beat_adr", wbs_adr_o, e.adr);
          chk("beat_we", wbs_we_o, e.we);
          chk("beat_sel", wbs_sel_o, e.sel);
          chk("beat_cti", wbs_cti_o, e.cti);
          chk("beat_bte", wbs_bte_o, e.bte);
          if (e.we) chk("beat_wdat", wbs_dat_o, e.dat);
          else chk("beat_rdat", wbm_dat_o[gi*DW +: DW], e.adr ^ KEY);
        end
      end
      // Reference arbitration: hold until cyc drops, then rotate
      if (gi < 0) begin
        if (m_cyc != '0) begin
          c = (mdl_last + 1) % N;
          while (!m_cyc[c]) c = (c + 1) % N;
          exp_gnt = '0;
          exp_gnt[c] = 1'b1;
          mdl_last = c;
        end
      end else if (!m_cyc[gi]) begin
        exp_gnt = '0;
      end
    end
  end

  // Random masters and slave
  beat_t bt[N][4];
  int len[N], bi[N], gap[N];
  bit act[N];
  logic [N-1:0] ack_seen;
  int s_wait;

  task automatic start_txn(input int m);
    logic [31:0] base;
    logic w;
    logic [1:0] b2;
    len[m] = ($urandom_range(0, 2) == 0) ? 4 : 1;
    base = 32'h1000 * (m + 1) + ($urandom_range(0, 255) << 4);
    w = 1'($urandom_range(0, 1));
    b2 = 2'($urandom_range(0, 3));
    for (int b = 0; b < len[m]; b++) begin
      bt[m][b].adr = base + 32'(4 * b);
      bt[m][b].dat = $urandom;
      bt[m][b].we = w;
      bt[m][b].sel = w ? 4'($urandom_range(1, 15)) : 4'hF;
      bt[m][b].bte = b2;
      if (len[m] == 1) bt[m][b].cti = CTI_CLASSIC;
      else if (b == 3) bt[m][b].cti = CTI_EOB;
      else bt[m][b].cti = CTI_INCR;
      exp_q[m].push_back(bt[m][b]);
    end
    bi[m] = 0;
    act[m] = 1'b1;
  endtask

  function automatic bit any_act();
    bit r;
    r = 1'b0;
    for (int m = 0; m < N; m++) r |= act[m];
    return r;
  endfunction

  task automatic run_cycle(input bit allow_new);
    beat_t b;
    for (int m = 0; m < N; m++) begin
      if (act[m]) begin
        if (ack_seen[m]) begin
          bi[m]++;
          if (bi[m] == len[m]) begin
            act[m] = 1'b0;
            gap[m] = $urandom_range(0, 3);
          end
        end
      end else if (gap[m] > 0) begin
        gap[m]--;
      end else if (allow_new && $urandom_range(0, 1) == 1) begin
        start_txn(m);
      end
      m_cyc[m] = act[m];
      m_stb[m] = act[m];
      if (act[m]) begin
        b = bt[m][bi[m]];
        m_adr[m*AW +: AW] = b.adr;
        m_dat[m*DW +: DW] = b.dat;
        m_sel[m*4 +: 4] = b.sel;
        m_we[m] = b.we;
        m_cti[m*3 +: 3] = b.cti;
        m_bte[m*2 +: 2] = b.bte;
      end
    end
    #1;
    s_ack = 1'b0;
    if (wbs_cyc_o && wbs_stb_o) begin
      if (s_wait == 0) begin
        s_ack = 1'b1;
        s_dat = wbs_adr_o ^ KEY;
        s_wait = $urandom_range(0, 2);
      end else begin
        s_wait--;
      end
    end
    @(negedge clk);
    ack_seen = wbm_ack_o;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dat = '0;
    s_wait = 0;
    ack_seen = '0;
    exp_gnt = '0;
    mdl_last = N - 1;
    for (int m = 0; m < N; m++) begin
      drv(m, 1'b0, 32'h0, CTI_CLASSIC);
      act[m] = 1'b0;
      gap[m] = 0;
      bi[m] = 0;
      len[m] = 1;
    end
    drv(0, 1'b1, 32'h100, CTI_CLASSIC);
    drv(1, 1'b1, 32'h200, CTI_CLASSIC);

    repeat (3) begin
      tick();
      chk("rst_grant", grant_o, 0);
      chk("rst_slv_cyc", wbs_cyc_o, 0);
      chk("rst_ack", wbm_ack_o, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("first_grant", grant_o, 3'b001);
    chk("first_adr", wbs_adr_o, 32'h100);
    chk("first_cyc", wbs_cyc_o, 1'b1);

    s_err = 1'b1;
    s_dat = 32'hDEADBEEF;
    #1;
    chk("err_route", wbm_err_o, 3'b001);
    chk("err_no_ack", wbm_ack_o, 0);
    for (int m = 0; m < N; m++)
      chk("dat_lane", wbm_dat_o[m*DW +: DW], 32'hDEADBEEF);
    s_err = 1'b0;
    s_rty = 1'b1;
    #1;
    chk("rty_route0", wbm_rty_o, 3'b001);
    s_rty = 1'b0;
    drv(0, 1'b0, 32'h100, CTI_CLASSIC);
    #1;
    chk("release_cyc", wbs_cyc_o, 1'b0);
    tick();
    chk("idle_gap", grant_o, 0);
    tick();
    chk("rotate_grant", grant_o, 3'b010);
    chk("rotate_adr", wbs_adr_o, 32'h200);
    s_rty = 1'b1;
    #1;
    chk("rty_route1", wbm_rty_o, 3'b010);
    s_rty = 1'b0;

    drv(1, 1'b0, 32'h200, CTI_CLASSIC);
    tick();
    tick();
    chk("idle_again", grant_o, 0);
    drv(2, 1'b1, 32'h400, CTI_CLASSIC);
    tick();
    chk("stall_grant", grant_o, 3'b100);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin
        s_ack = 1'b1;
        #1;
        chk("wd_err", wbm_err_o, 3'b100);
        chk("wd_stb", wbs_stb_o, 1'b0);
        chk("wd_cyc", wbs_cyc_o, 1'b0);
        chk("wd_ack_blocked", wbm_ack_o, 0);
        s_ack = 1'b0;
      end else begin
        chk("wd_quiet", wbm_err_o, 0);
        chk("wd_stb_hi", wbs_stb_o, 1'b1);
      end
      tick();
    end
`else
    for (int k = 0; k < 20; k++) begin
      chk("stall_no_err", wbm_err_o, 0);
      chk("stall_stb_hi", wbs_stb_o, 1'b1);
      tick();
    end
`endif
    chk("stall_grant_kept", grant_o, 3'b100);

    drv(2, 1'b0, 32'h400, CTI_CLASSIC);
    tick();
    tick();
    drv(1, 1'b1, 32'h300, CTI_INCR);
    s_ack = 1'b1;
    tick();
    chk("burst_grant", grant_o, 3'b010);
    chk("burst_ack0", wbm_ack_o, 3'b010);
    tick();
    chk("burst_ack1", wbm_ack_o, 3'b010);
    tick();
    drv(0, 1'b1, 32'h100, CTI_CLASSIC);
    drv(2, 1'b1, 32'h400, CTI_CLASSIC);
    rst_n = 1'b0;
    #1;
    chk("burst_ack2", wbm_ack_o, 3'b010);
    chk("burst_hold", grant_o, 3'b010);
    tick();
    chk("mid_rst_cyc", wbs_cyc_o, 1'b0);
    chk("mid_rst_ack", wbm_ack_o, 0);
    chk("mid_rst_grant", grant_o, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_grant", grant_o, 3'b001);

    rst_n = 1'b0;
    s_ack = 1'b0;
    for (int m = 0; m < N; m++) drv(m, 1'b0, 32'h0, CTI_CLASSIC);
    tick();
    tick();
    rst_n = 1'b1;
    exp_gnt = '0;
    mdl_last = N - 1;
    mon_en = 1'b1;
    repeat (3000) run_cycle(1'b1);
    w = 0;
    while (any_act() && w < 400) begin
      run_cycle(1'b0);
      w++;
    end
    chk("drain_done", any_act(), 1'b0);
    run_cycle(1'b0);
    run_cycle(1'b0);
    mon_en = 1'b0;
    for (int m = 0; m < N; m++)
      chk("leftover_beats", exp_q[m].size(), 0);
    chk("beats_seen", n_beats > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
